fetch_unit: RTL
===============

# fetch_unit

Parametrised instruction-fetch sequencer for the TinyMIPS datapath. It assembles an IWIDTH-bit instruction from BUSW-bit memory beats and maintains the program counter. It holds the assembled word behind a valid/ready handshake. It generalises the fixed four-byte, one-hot `irwrite` loading into a self-sequencing block with variable widths, memory wait states, PC redirect and abort.

## Interface
- XLEN, 8: address and PC width; addresses wrap modulo 2^XLEN.
- IWIDTH, 32: instruction width; must be an integer multiple of BUSW.
- BUSW, 8: memory data bus width.
- RESET_PC, 0: PC value after reset.
- BEATS (localparam) = IWIDTH/BUSW. Must be ≥ 2; elaboration error otherwise.

- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request one instruction fetch. Honoured only in IDLE, or in VALID together with instr_ready.
- pc_load  in  1  redirect the PC; aborts any fetch in progress.
- pc_in  in  XLEN  new PC value, used when pc_load=1.
- mem_req  out  1  memory read request for the current beat.
- mem_adr  out  XLEN  byte address = (pc + beat) mod 2^XLEN.
- memdata  in  BUSW  read data; sampled only when mem_req & mem_ack.
- mem_ack  in  1  memory data valid this cycle; may be tied high for zero-wait memory.
- instr  out  IWIDTH  assembled instruction register.
- instr_valid  out  1  instr is complete and held.
- instr_ready  in  1  consumer accepts instr.
- pc  out  XLEN  current program counter.
- busy  out  1  state ≠ IDLE.

## Operation
- States:
  - IDLE: mem_req=0.
  - FETCH: mem_req=1; beat counter runs 0..BEATS-1.
  - VALID: instr_valid=1.
- IDLE → FETCH on start=1 (with pc_load=0). Beat counter is cleared to 0.
- In FETCH, a cycle with mem_ack=1 writes memdata into lane `beat`, i.e. instr[beat*BUSW +: BUSW].
  - Little-endian: beat 0 is the LSB lane.
  - If beat = BEATS-1, go to VALID; otherwise beat increments.
  - mem_ack=0 holds the beat and mem_adr (wait state). Request and address stay stable until ack.
- VALID holds instr and instr_valid until instr_ready=1. On acceptance:
  - pc ← pc + BEATS (mod 2^XLEN).
  - Go to FETCH (beat 0) if start=1 the same cycle, else IDLE.
  - The back-to-back fetch uses the incremented PC.
- pc_load=1 in any state, same cycle:
  - pc ← pc_in and state → IDLE; start is ignored that cycle.
  - A partially assembled instr is discarded: instr_valid stays 0, lanes keep stale data.
  - pc_load has priority over mem_ack, instr_ready and start.
- Lanes not yet written in the current fetch keep their previous values. instr is defined only while instr_valid=1.
- start in FETCH, or in VALID without instr_ready, is ignored (not queued).
- mem_adr is decoded from registered pc and beat only; it has no combinational path from inputs.

## Timing
- Reset values:
  - state IDLE, beat 0.
  - pc = RESET_PC, instr = 0.
  - mem_req = 0, instr_valid = 0, busy = 0.
  - mem_adr = RESET_PC.
- Reset mid-fetch or mid-VALID has the same effect; it overrides pc_load.
- Zero-wait latency: start sampled at edge N; mem_req high after N; beats captured at edges N+1..N+BEATS; instr_valid high after edge N+BEATS.
  - For BEATS=4, that is 4 cycles from the start edge.
  - Each wait cycle adds 1.
- Sustained throughput with start and instr_ready held high and zero-wait memory: one instruction per BEATS+1 cycles.
- PC increments exactly once per accepted instruction, never per beat.
- The PC wraps modulo 2^XLEN. Beat addresses within one fetch also wrap (pc=0xFE, BEATS=4 → 0xFE, 0xFF, 0x00, 0x01).

## Test plan
- Reset: assert reset 2 cycles with start=1 → pc=0x00, instr=0, mem_req=0, instr_valid=0, busy=0. Nothing starts until reset is released.
- ADD fetch (defaults, mem_ack=1): memory at 0..3 = 0x20, 0x08, 0x43, 0x00; pulse start.
  - mem_adr must step 0, 1, 2, 3.
  - instr_valid must rise 4 cycles after the start edge with instr=0x00430820.
  - After instr_ready, pc=0x04.
- Wait states: mem_ack low for 2 cycles on beat 1 → mem_adr held at 0x01 and mem_req held high. instr=0x00430820 with instr_valid 2 cycles later than in the zero-wait case.
- Wrap: pc_load with pc_in=0xFE, then fetch → addresses 0xFE, 0xFF, 0x00, 0x01; pc=0x02 after accept.
- Abort and priority:
  - pc_load=1 (pc_in=0x40) during beat 2 → IDLE next cycle, pc=0x40, instr_valid never asserted.
  - A new start then fetches from 0x40.
  - pc_load together with instr_ready in VALID → pc=pc_in, not pc+4.
- Back-to-back: start and instr_ready held high for 3 instructions from pc=0 → accepted words from 0x00, 0x04, 0x08. instr_valid pulses exactly one cycle each, 5 cycles apart; final pc=0x0C.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: handshake and memory-bus bundle for fetch_unit.
//   start/pc_load/pc_in : fetch request and PC redirect (consumer -> fetch)
//   mem_req/mem_adr     : beat read request and byte address (fetch -> memory)
//   memdata/mem_ack     : beat data and data-valid strobe (memory -> fetch)
//   instr/instr_valid   : assembled instruction, held until accepted
//   instr_ready         : consumer accepts instr
//   pc/busy             : current program counter, sequencer not idle
// master = the fetch unit side, slave = its environment.
interface fetch_if #(
  parameter int XLEN   = 8,
  parameter int IWIDTH = 32,
  parameter int BUSW   = 8
);
  logic              start;
  logic              pc_load;
  logic [XLEN-1:0]   pc_in;
  logic              mem_req;
  logic [XLEN-1:0]   mem_adr;
  logic [BUSW-1:0]   memdata;
  logic              mem_ack;
  logic [IWIDTH-1:0] instr;
  logic              instr_valid;
  logic              instr_ready;
  logic [XLEN-1:0]   pc;
  logic              busy;

  modport master (
    input  start, pc_load, pc_in, memdata, mem_ack, instr_ready,
    output mem_req, mem_adr, instr, instr_valid, pc, busy
  );

  modport slave (
    output start, pc_load, pc_in, memdata, mem_ack, instr_ready,
    input  mem_req, mem_adr, instr, instr_valid, pc, busy
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch sequencer. Assembles an IWIDTH-bit word from
// BEATS little-endian BUSW-bit memory beats, holds it behind valid/ready and
// advances the PC by BEATS once per accepted instruction.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : fetch_if.master (request/redirect, memory bus, instruction handshake)
module fetch_unit #(
  parameter int              XLEN     = 8,
  parameter int              IWIDTH   = 32,
  parameter int              BUSW     = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);
  localparam int BEATS = IWIDTH / BUSW;
  // Guard the width so a bad parameter set reaches the error below cleanly.
  localparam int BW    = (BEATS < 2) ? 1 : $clog2(BEATS);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  generate
    if (BEATS < 2 || (IWIDTH % BUSW) != 0) begin : g_bad_params
      $error("fetch_unit: IWIDTH must be a multiple of BUSW giving at least 2 beats");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_VALID} state_t;

  state_t                     r_state, w_state_nxt;
  logic [BW-1:0]              r_beat,  w_beat_nxt;
  logic [XLEN-1:0]            r_pc,    w_pc_nxt;
  logic [BEATS-1:0][BUSW-1:0] r_instr;
  logic                       w_cap;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // pc_load outranks everything else, including an ack or acceptance
  // arriving in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_pc_nxt    = r_pc;
    w_cap       = 1'b0;
    if (bus.pc_load) begin
      w_state_nxt = S_IDLE;
      w_beat_nxt  = '0;
      w_pc_nxt    = bus.pc_in;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            w_state_nxt = S_FETCH;
            w_beat_nxt  = '0;
          end
        end
        S_FETCH: begin
          if (bus.mem_ack) begin
            w_cap = 1'b1;
            if (r_beat == LAST) w_state_nxt = S_VALID;
            else                w_beat_nxt  = r_beat + 1'b1;
          end
        end
        S_VALID: begin
          if (bus.instr_ready) begin
            w_pc_nxt   = r_pc + XLEN'(BEATS);
            w_beat_nxt = '0;
            w_state_nxt = bus.start ? S_FETCH : S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_beat_nxt  = '0;
        end
      endcase
    end
  end

  // Only the lane of the current beat is written; others keep stale data,
  // which is why an aborted fetch needs no clean-up here.
  always_ff @(posedge clk) begin
    if (reset)      r_instr         <= '0;
    else if (w_cap) r_instr[r_beat] <= bus.memdata;
  end

  // Address comes from registered state only; it wraps naturally in XLEN bits.
  assign bus.mem_adr     = r_pc + XLEN'(r_beat);
  assign bus.mem_req     = (r_state == S_FETCH);
  assign bus.instr_valid = (r_state == S_VALID);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.instr       = r_instr;
  assign bus.pc          = r_pc;
endmodule
